// File: rtl/ram_copy_if.sv
// ram_copy_if: RAM port bundle between the copy engine (master) and the asynchronous RAM (slave).
interface ram_copy_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_write;
  modport master (output mem_address, mem_wdata, mem_write, input mem_rdata);
  modport slave  (input mem_address, mem_wdata, mem_write, output mem_rdata);
endinterface

// File: rtl/ram_copy_engine.sv
// ram_copy_engine: copies length words src->dst through an async RAM port with a registered, glitch-free write strobe.
// Optional RAM_COPY_CHECKSUM_EN adds a running sum of every word read.
module ram_copy_engine #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
`ifdef RAM_COPY_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  ram_copy_if.master        mem
);
  typedef enum logic [2:0] {IDLE, RD, WS, WR, WH} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d, done_q, done_d;
  logic              accept;
  assign accept = (state_q == IDLE) && start;
  // Address only moves on RD->WS and WH->RD, so it never changes around a strobe-high cycle.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    wdata_d = wdata_q;
    write_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        src_d  = src_addr;
        dst_d  = dst_addr;
        rem_d  = length;
        done_d = (length == '0);
        state_d = (length == '0) ? IDLE : RD;
        addr_d  = (length == '0) ? addr_q : src_addr;
      end
      RD: begin
        wdata_d = mem.mem_rdata;
        addr_d  = dst_q;
        state_d = WS;
      end
      WS: begin
        write_d = 1'b1;
        state_d = WR;
      end
      WR: state_d = WH;
      WH: begin
        src_d   = src_q + 1'b1;
        dst_d   = dst_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        done_d  = (rem_q == (ADDR_W+1)'(1));
        state_d = done_d ? IDLE : RD;
        addr_d  = done_d ? addr_q : src_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      done_q  <= done_d;
    end
  end
  assign busy            = state_q != IDLE;
  assign done            = done_q;
  assign mem.mem_address = addr_q;
  assign mem.mem_wdata   = wdata_q;
  assign mem.mem_write   = write_q;
`ifdef RAM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] chk_q, chk_d;
  always_comb begin
    chk_d = accept ? '0 : (state_q == RD) ? chk_q + mem.mem_rdata : chk_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chk_q <= '0;
    else     chk_q <= chk_d;
  end
  assign checksum = chk_q;
`endif
endmodule

// File: tb/tb_ram_copy_engine.sv
// tb_ram_copy_engine: directed scenarios on a 6-bit and a 5-bit address instance with behavioural RAMs.
module tb_ram_copy_engine;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic       start6 = 0, busy6, done6;
  logic [5:0] src6 = 0, dst6 = 0;
  logic [6:0] len6 = 0;
  logic       start5 = 0, busy5, done5;
  logic [4:0] src5 = 0, dst5 = 0;
  logic [5:0] len5 = 0;
`ifdef RAM_COPY_CHECKSUM_EN
  logic [31:0] chk6, chk5;
`endif

  ram_copy_if #(.ADDR_W(6), .DATA_W(32)) bus6 ();
  ram_copy_if #(.ADDR_W(5), .DATA_W(32)) bus5 ();

  ram_copy_engine #(.ADDR_W(6), .DATA_W(32)) dut6 (
    .clk(clk), .rst(rst), .start(start6), .src_addr(src6), .dst_addr(dst6),
    .length(len6), .busy(busy6), .done(done6),
`ifdef RAM_COPY_CHECKSUM_EN
    .checksum(chk6),
`endif
    .mem(bus6));

  ram_copy_engine #(.ADDR_W(5), .DATA_W(32)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .src_addr(src5), .dst_addr(dst5),
    .length(len5), .busy(busy5), .done(done5),
`ifdef RAM_COPY_CHECKSUM_EN
    .checksum(chk5),
`endif
    .mem(bus5));

  logic [31:0] ram6 [64];
  logic [31:0] ram5 [32];
  logic        init_en = 0, poke_en = 0;
  logic [5:0]  poke_a = 0;
  logic [31:0] poke_d = 0;
  assign bus6.mem_rdata = ram6[bus6.mem_address];
  assign bus5.mem_rdata = ram5[bus5.mem_address];
  always @(posedge clk) begin
    if (init_en) for (int i = 0; i < 64; i++) ram6[i] <= 32'(i + 256);
    else if (poke_en) ram6[poke_a] <= poke_d;
    else if (bus6.mem_write) ram6[bus6.mem_address] <= bus6.mem_wdata;
  end
  always @(posedge clk) begin
    if (init_en) for (int i = 0; i < 32; i++) ram5[i] <= 32'(i + 256);
    else if (bus5.mem_write) ram5[bus5.mem_address] <= bus5.mem_wdata;
  end

  int viol = 0, wr_cnt = 0, done_cnt = 0;
  logic [5:0]  a_p = 0;
  logic [31:0] d_p = 0;
  logic        w_p = 0, rst_p = 1;
  // Address/data may only move across an edge with the strobe low on both sides.
  always @(posedge clk) begin
    #1;
    if (!rst && !rst_p && (bus6.mem_write || w_p) &&
        (bus6.mem_address !== a_p || bus6.mem_wdata !== d_p)) viol++;
    if (bus6.mem_write) wr_cnt++;
    if (done6) done_cnt++;
    a_p = bus6.mem_address; d_p = bus6.mem_wdata; w_p = bus6.mem_write; rst_p = rst;
  end

  int cmp = 0, err = 0;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input bit sel5, output int n);
    n = 0;
    while ((sel5 ? busy5 : busy6) && n < 100) begin n++; tick(); end
  endtask

  task automatic init_ram;
    init_en = 1; tick(); init_en = 0;
  endtask

  task automatic test_reset;
    rst = 1; tick(); tick();
    cmp++; if (busy6 !== 0 || done6 !== 0) begin err++; $display("FAIL reset_ctrl busy=%b done=%b expected 0 0", busy6, done6); end
    cmp++; if (bus6.mem_write !== 0 || bus6.mem_address !== 0 || bus6.mem_wdata !== 0) begin err++;
      $display("FAIL reset_bus write=%b addr=%h wdata=%h expected 0 0 0", bus6.mem_write, bus6.mem_address, bus6.mem_wdata); end
`ifdef RAM_COPY_CHECKSUM_EN
    cmp++; if (chk6 !== 0) begin err++; $display("FAIL reset_checksum got %h expected 0", chk6); end
`endif
    rst = 0; tick();
  endtask

  task automatic test_basic_copy;
    int n, d0;
    init_ram();
    d0 = done_cnt;
    src6 = 2; dst6 = 20; len6 = 3; start6 = 1; tick(); start6 = 0;
    wait_idle(0, n);
    cmp++; if (n !== 12) begin err++; $display("FAIL basic_busy_cycles got %0d expected 12", n); end
    cmp++; if (done6 !== 1) begin err++; $display("FAIL basic_done got %b expected 1", done6); end
`ifdef RAM_COPY_CHECKSUM_EN
    cmp++; if (chk6 !== 32'h309) begin err++; $display("FAIL basic_checksum got %h expected 309", chk6); end
`endif
    tick();
    cmp++; if (done6 !== 0) begin err++; $display("FAIL basic_done_pulse got %b expected 0", done6); end
    cmp++; if (done_cnt - d0 !== 1) begin err++; $display("FAIL basic_done_count got %0d expected 1", done_cnt - d0); end
    cmp++; if (ram6[20] !== 32'h102 || ram6[21] !== 32'h103 || ram6[22] !== 32'h104) begin err++;
      $display("FAIL basic_data got %h %h %h expected 102 103 104", ram6[20], ram6[21], ram6[22]); end
    cmp++; if (ram6[19] !== 32'h113 || ram6[23] !== 32'h117) begin err++;
      $display("FAIL basic_neighbours got %h %h expected 113 117", ram6[19], ram6[23]); end
  endtask

  task automatic test_zero_length;
    int w0;
    w0 = wr_cnt;
    src6 = 5; dst6 = 9; len6 = 0; start6 = 1; tick(); start6 = 0;
    cmp++; if (busy6 !== 0 || done6 !== 1) begin err++; $display("FAIL zero_first busy=%b done=%b expected 0 1", busy6, done6); end
    tick();
    cmp++; if (busy6 !== 0 || done6 !== 0) begin err++; $display("FAIL zero_after busy=%b done=%b expected 0 0", busy6, done6); end
    tick();
    cmp++; if (wr_cnt !== w0) begin err++; $display("FAIL zero_writes got %0d expected %0d", wr_cnt, w0); end
  endtask

  task automatic test_wrap;
    int n;
    init_ram();
    src5 = 30; dst5 = 0; len5 = 4; start5 = 1; tick(); start5 = 0;
    wait_idle(1, n);
    cmp++; if (n !== 16 || done5 !== 1) begin err++; $display("FAIL wrap_timing cycles=%0d done=%b expected 16 1", n, done5); end
    tick();
    cmp++; if (ram5[0] !== 32'h11E || ram5[1] !== 32'h11F || ram5[2] !== 32'h11E || ram5[3] !== 32'h11F) begin err++;
      $display("FAIL wrap_data got %h %h %h %h expected 11e 11f 11e 11f", ram5[0], ram5[1], ram5[2], ram5[3]); end
  endtask

  task automatic test_overlap_back_to_back;
    int n;
    init_ram();
    poke_a = 4; poke_d = 32'hA; poke_en = 1; tick(); poke_en = 0;
    src6 = 4; dst6 = 5; len6 = 4; start6 = 1; tick(); start6 = 0;
    tick(); tick();
    src6 = 0; dst6 = 40; len6 = 1; start6 = 1; tick(); start6 = 0;
    wait_idle(0, n);
    cmp++; if (n !== 13 || done6 !== 1) begin err++; $display("FAIL overlap_timing cycles=%0d done=%b expected 13 1", n, done6); end
    src6 = 10; dst6 = 30; len6 = 1; start6 = 1; tick(); start6 = 0;
    cmp++; if (busy6 !== 1) begin err++; $display("FAIL b2b_accept busy=%b expected 1", busy6); end
    wait_idle(0, n);
    cmp++; if (n !== 4) begin err++; $display("FAIL b2b_cycles got %0d expected 4", n); end
    tick();
    cmp++; if (ram6[5] !== 32'hA || ram6[6] !== 32'hA || ram6[7] !== 32'hA || ram6[8] !== 32'hA || ram6[9] !== 32'h109) begin err++;
      $display("FAIL overlap_data got %h %h %h %h %h expected a a a a 109", ram6[5], ram6[6], ram6[7], ram6[8], ram6[9]); end
    cmp++; if (ram6[40] !== 32'h128) begin err++; $display("FAIL ignored_start ram40=%h expected 128", ram6[40]); end
    cmp++; if (ram6[30] !== 32'h10A) begin err++; $display("FAIL b2b_data ram30=%h expected 10a", ram6[30]); end
  endtask

  task automatic test_reset_mid_copy;
    int d0;
    init_ram();
    src6 = 0; dst6 = 50; len6 = 4; start6 = 1; tick(); start6 = 0;
    repeat (10) tick();
    cmp++; if (bus6.mem_write !== 1 || bus6.mem_address !== 6'd52) begin err++;
      $display("FAIL abort_setup write=%b addr=%0d expected 1 52", bus6.mem_write, bus6.mem_address); end
    #2 rst = 1;
    #1;
    cmp++; if (bus6.mem_write !== 0 || busy6 !== 0 || bus6.mem_address !== 0) begin err++;
      $display("FAIL abort_async write=%b busy=%b addr=%0d expected 0 0 0", bus6.mem_write, busy6, bus6.mem_address); end
    d0 = done_cnt;
    tick(); tick(); rst = 0;
    repeat (6) tick();
    cmp++; if (done_cnt !== d0 || busy6 !== 0) begin err++; $display("FAIL abort_no_done dones=%0d busy=%b expected %0d 0", done_cnt, busy6, d0); end
    cmp++; if (ram6[50] !== 32'h100 || ram6[51] !== 32'h101 || (ram6[52] !== 32'h134 && ram6[52] !== 32'h102) || ram6[53] !== 32'h135) begin err++;
      $display("FAIL abort_data got %h %h %h %h expected 100 101 134|102 135", ram6[50], ram6[51], ram6[52], ram6[53]); end
  endtask

  task automatic test_protocol;
    cmp++; if (viol !== 0) begin err++; $display("FAIL protocol_stability violations=%0d expected 0", viol); end
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_zero_length();
    test_wrap();
    test_overlap_back_to_back();
    test_reset_mid_copy();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
